telem_rx: RTL and testbench



---
 rtl/telem_rx.sv | 192 +++++++++++++++++++
 tb/tb_telem_rx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telem_rx.sv
// telem_rx: 8N1 UART receiver and telemetry frame parser.
// Deserializes bytes from RX, locks onto the 0xAA/0x55 header, and reassembles
// the 12-bit battery, current and torque readings of each 8-byte frame.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   RX       serial input, idle high, asynchronous to clk
//   batt     last good battery reading
//   curr     last good current reading
//   torque   last good torque reading
//   vld      one-cycle pulse when a good frame has been loaded
//   frm_err  one-cycle pulse on a stop-bit error or malformed frame
module telem_rx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err
);

  localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_M1 = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bitState_t;
  typedef enum logic [2:0] {
    HUNT_AA, HUNT_55, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO
  } frmState_t;

  logic        rxMeta, rxS, rxPrev;
  bitState_t   bitState;
  logic [11:0] cnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shReg;
  logic        byteRdy, stopErr;

  frmState_t   frmState;
  logic [3:0]  bHi, cHi, tHi;
  logic [7:0]  bLo, cLo;

  // Stop-bit decision is combinational so the frame FSM consumes the byte on
  // the same edge; registered frame outputs then appear one cycle later.
  always_comb begin
    byteRdy = 1'b0;
    stopErr = 1'b0;
    if (bitState == STOP && cnt == FULL_M1) begin
      byteRdy = rxS;
      stopErr = !rxS;
    end
  end

  // Synchronizer and bit-level receive FSM. The counter is cleared on the
  // falling edge, so the start check lands BAUD_DIV/2 cycles after rx_s first
  // reads 0 and each later sample lands a whole bit period after the previous.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta   <= 1'b1;
      rxS      <= 1'b1;
      rxPrev   <= 1'b1;
      bitState <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shReg    <= '0;
    end else begin
      rxMeta <= RX;
      rxS    <= rxMeta;
      rxPrev <= rxS;
      case (bitState)
        IDLE: begin
          if (rxPrev && !rxS) begin
            bitState <= START;
            cnt      <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxS) begin
              bitState <= DATA;
              bitIdx   <= '0;
            end else begin
              bitState <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shReg <= {rxS, shReg[7:1]};
            if (bitIdx == 3'd7) bitState <= STOP;
            else                bitIdx   <= bitIdx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            bitState <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: bitState <= IDLE;
      endcase
    end
  end

  // Frame FSM. Readings are staged in holding registers and only committed to
  // the outputs together on a good T_LO byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      frmState <= HUNT_AA;
      bHi      <= '0;
      cHi      <= '0;
      tHi      <= '0;
      bLo      <= '0;
      cLo      <= '0;
      batt     <= '0;
      curr     <= '0;
      torque   <= '0;
      vld      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      vld     <= 1'b0;
      frm_err <= 1'b0;
      if (stopErr) begin
        frm_err  <= 1'b1;
        frmState <= HUNT_AA;
      end else if (byteRdy) begin
        case (frmState)
          HUNT_AA: if (shReg == 8'hAA) frmState <= HUNT_55;
          HUNT_55: begin
            if (shReg == 8'h55)      frmState <= B_HI;
            else if (shReg != 8'hAA) frmState <= HUNT_AA;
          end
          B_HI: begin
            if (shReg[7:4] != '0) begin
              frm_err  <= 1'b1;
              frmState <= HUNT_AA;
            end else begin
              bHi      <= shReg[3:0];
              frmState <= B_LO;
            end
          end
          B_LO: begin
            bLo      <= shReg;
            frmState <= C_HI;
          end
          C_HI: begin
            if (shReg[7:4] != '0) begin
              frm_err  <= 1'b1;
              frmState <= HUNT_AA;
            end else begin
              cHi      <= shReg[3:0];
              frmState <= C_LO;
            end
          end
          C_LO: begin
            cLo      <= shReg;
            frmState <= T_HI;
          end
          T_HI: begin
            if (shReg[7:4] != '0) begin
              frm_err  <= 1'b1;
              frmState <= HUNT_AA;
            end else begin
              tHi      <= shReg[3:0];
              frmState <= T_LO;
            end
          end
          T_LO: begin
            batt     <= {bHi, bLo};
            curr     <= {cHi, cLo};
            torque   <= {tHi, shReg};
            vld      <= 1'b1;
            frmState <= HUNT_AA;
          end
          default: frmState <= HUNT_AA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_telem_rx.sv
module tb_telem_rx;

  localparam int unsigned DIV_A = 16;
  localparam int unsigned DIV_B = 434;
  localparam int unsigned PER_B = 426;  // transmitter about 2% fast

  logic clk = 1'b0;
  logic rst = 1'b1, rstB = 1'b1;
  logic rxA = 1'b1, rxB = 1'b1;
  logic [11:0] battA, currA, torqA, battB, currB, torqB;
  logic vldA, errA, vldB, errB;

  int vectors = 0, miscompares = 0;
  int vCntA = 0, eCntA = 0, vCntB = 0, eCntB = 0;
  int streamA[$], streamB[$];  // byte values, -1 marks a byte with a bad stop bit
  logic [35:0] prevA, prevB;

  always #5 clk = ~clk;

  telem_rx #(.BAUD_DIV(DIV_A)) dutA (
    .clk(clk), .rst(rst), .RX(rxA),
    .batt(battA), .curr(currA), .torque(torqA),
    .vld(vldA), .frm_err(errA)
  );

  telem_rx #(.BAUD_DIV(DIV_B)) dutB (
    .clk(clk), .rst(rstB), .RX(rxB),
    .batt(battB), .curr(currB), .torque(torqB),
    .vld(vldB), .frm_err(errB)
  );

  // Reference: scan the received byte stream for frames.
  function automatic void model(input int s[$], output int nV, output int nE,
                                output logic [35:0] outs);
    int n, i, j, k, v;
    bit bad;
    logic [7:0] p [6];
    n = s.size(); i = 0;
    nV = 0; nE = 0; outs = '0;
    while (i < n) begin
      if (s[i] != 'hAA) begin
        if (s[i] < 0) nE++;
        i++;
        continue;
      end
      j = i + 1;
      while (j < n && s[j] == 'hAA) j++;
      if (j >= n) break;
      if (s[j] != 'h55) begin
        if (s[j] < 0) nE++;
        i = j + 1;
        continue;
      end
      bad = 1'b0; k = 0;
      while (k < 6 && j + 1 + k < n) begin
        v = s[j + 1 + k];
        if (v < 0 || (k % 2 == 0 && v > 15)) begin
          nE++;
          bad = 1'b1;
          break;
        end
        p[k] = v[7:0];
        k++;
      end
      if (bad) i = j + 2 + k;
      else if (k < 6) i = n;
      else begin
        nV++;
        outs = {p[0][3:0], p[1], p[2][3:0], p[3], p[4][3:0], p[5]};
        i = j + 7;
      end
    end
  endfunction

  function automatic void mkFrame(input logic [11:0] b, input logic [11:0] c,
                                  input logic [11:0] t, output logic [7:0] f [8]);
    f[0] = 8'hAA; f[1] = 8'h55;
    f[2] = {4'h0, b[11:8]}; f[3] = b[7:0];
    f[4] = {4'h0, c[11:8]}; f[5] = c[7:0];
    f[6] = {4'h0, t[11:8]}; f[7] = t[7:0];
  endfunction

  task automatic sendByte(input bit onB, input logic [7:0] b, input bit stopOk,
                          input int unsigned per);
    logic [9:0] fr;
    fr = {stopOk, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (onB) rxB = fr[i]; else rxA = fr[i];
      repeat (per) @(negedge clk);
    end
    if (onB) streamB.push_back(stopOk ? int'(b) : -1);
    else     streamA.push_back(stopOk ? int'(b) : -1);
    if (!stopOk) begin
      if (onB) rxB = 1'b1; else rxA = 1'b1;
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input bit onB, input logic [11:0] b, input logic [11:0] c,
                           input logic [11:0] t, input int unsigned per);
    logic [7:0] f [8];
    mkFrame(b, c, t, f);
    for (int i = 0; i < 8; i++) sendByte(onB, f[i], 1'b1, per);
  endtask

  // Counts strobes and guards output integrity, sampled between clock edges.
  always @(posedge clk) begin
    #2;
    if (rst) prevA = {battA, currA, torqA};
    else begin
      if (vldA) vCntA++;
      if (errA) eCntA++;
      if (vldA || errA) begin
        vectors++;
        if (vldA && errA) begin
          $display("FAIL strobe_overlap_A: vld=%b frm_err=%b, both may not be 1", vldA, errA);
          miscompares++;
        end
      end
      if ({battA, currA, torqA} !== prevA) begin
        vectors++;
        if (!vldA) begin
          $display("FAIL output_integrity_A: outputs %h without vld, expected %h", {battA, currA, torqA}, prevA);
          miscompares++;
        end
        prevA = {battA, currA, torqA};
      end
    end
    if (rstB) prevB = {battB, currB, torqB};
    else begin
      if (vldB) vCntB++;
      if (errB) eCntB++;
      if ({battB, currB, torqB} !== prevB) begin
        vectors++;
        if (!vldB) begin
          $display("FAIL output_integrity_B: outputs %h without vld, expected %h", {battB, currB, torqB}, prevB);
          miscompares++;
        end
        prevB = {battB, currB, torqB};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({battA, currA, torqA, vldA, errA} !== 38'd0) begin
      $display("FAIL reset_A: got %h, expected 0", {battA, currA, torqA, vldA, errA});
      miscompares++;
    end
    vectors++;
    if ({battB, currB, torqB, vldB, errB} !== 38'd0) begin
      $display("FAIL reset_B: got %h, expected 0", {battB, currB, torqB, vldB, errB});
      miscompares++;
    end
    rst = 1'b0; rstB = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int eV, eE; logic [35:0] eO;
    sendFrame(1'b0, 12'hABC, 12'h123, 12'h7FF, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE) begin
      $display("FAIL good_frame_counts: vld=%0d err=%0d, expected vld=%0d err=%0d", vCntA, eCntA, eV, eE);
      miscompares++;
    end
    vectors++;
    if ({battA, currA, torqA} !== 36'hABC_123_7FF) begin
      $display("FAIL good_frame_outputs: got %h, expected abc1237ff", {battA, currA, torqA});
      miscompares++;
    end
  endtask

  task automatic test_resync();
    int eV, eE; logic [35:0] eO;
    logic [7:0] seq [10];
    seq = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    for (int i = 0; i < 10; i++) sendByte(1'b0, seq[i], 1'b1, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE) begin
      $display("FAIL resync_counts: vld=%0d err=%0d, expected vld=%0d err=%0d", vCntA, eCntA, eV, eE);
      miscompares++;
    end
    vectors++;
    if ({battA, currA, torqA} !== 36'h001_002_003) begin
      $display("FAIL resync_outputs: got %h, expected 001002003", {battA, currA, torqA});
      miscompares++;
    end
  endtask

  task automatic test_bad_stop();
    int eV, eE; logic [35:0] eO;
    logic [7:0] f [8];
    mkFrame(12'($urandom), 12'($urandom), 12'($urandom), f);
    for (int i = 0; i < 8; i++) sendByte(1'b0, f[i], i != 3, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE || {battA, currA, torqA} !== eO) begin
      $display("FAIL bad_stop: vld=%0d err=%0d out=%h, expected vld=%0d err=%0d out=%h",
               vCntA, eCntA, {battA, currA, torqA}, eV, eE, eO);
      miscompares++;
    end
    sendFrame(1'b0, 12'hFFF, 12'h000, 12'h800, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE) begin
      $display("FAIL bad_stop_recover_counts: vld=%0d err=%0d, expected vld=%0d err=%0d", vCntA, eCntA, eV, eE);
      miscompares++;
    end
    vectors++;
    if ({battA, currA, torqA} !== eO) begin
      $display("FAIL bad_stop_recover_outputs: got %h, expected %h", {battA, currA, torqA}, eO);
      miscompares++;
    end
  endtask

  task automatic test_nibble();
    int eV, eE; logic [35:0] eO;
    sendByte(1'b0, 8'hAA, 1'b1, DIV_A);
    sendByte(1'b0, 8'h55, 1'b1, DIV_A);
    sendByte(1'b0, 8'hF5, 1'b1, DIV_A);
    repeat (5) sendByte(1'b0, 8'($urandom_range(0, 8'h7F)), 1'b1, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE) begin
      $display("FAIL nibble_counts: vld=%0d err=%0d, expected vld=%0d err=%0d", vCntA, eCntA, eV, eE);
      miscompares++;
    end
    vectors++;
    if ({battA, currA, torqA} !== eO) begin
      $display("FAIL nibble_outputs: got %h, expected %h", {battA, currA, torqA}, eO);
      miscompares++;
    end
  endtask

  task automatic test_glitch();
    int eV, eE; logic [35:0] eO;
    rxA = 1'b0;
    repeat (DIV_A / 4) @(negedge clk);
    rxA = 1'b1;
    repeat (DIV_A) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE) begin
      $display("FAIL glitch_quiet: vld=%0d err=%0d, expected vld=%0d err=%0d", vCntA, eCntA, eV, eE);
      miscompares++;
    end
    sendFrame(1'b0, 12'($urandom), 12'($urandom), 12'($urandom), DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE || {battA, currA, torqA} !== eO) begin
      $display("FAIL glitch_frame: vld=%0d err=%0d out=%h, expected vld=%0d err=%0d out=%h",
               vCntA, eCntA, {battA, currA, torqA}, eV, eE, eO);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int eV, eE; logic [35:0] eO;
    logic [7:0] f [8];
    mkFrame(12'($urandom), 12'($urandom), 12'($urandom), f);
    for (int i = 0; i < 5; i++) sendByte(1'b0, f[i], 1'b1, DIV_A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    streamA.delete();
    vCntA = 0; eCntA = 0;
    vectors++;
    if ({battA, currA, torqA} !== 36'd0) begin
      $display("FAIL reset_mid_outputs: got %h, expected 0", {battA, currA, torqA});
      miscompares++;
    end
    for (int i = 5; i < 8; i++) sendByte(1'b0, f[i], 1'b1, DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE || {battA, currA, torqA} !== eO) begin
      $display("FAIL reset_mid_tail: vld=%0d err=%0d out=%h, expected vld=%0d err=%0d out=%h",
               vCntA, eCntA, {battA, currA, torqA}, eV, eE, eO);
      miscompares++;
    end
    sendFrame(1'b0, 12'($urandom), 12'($urandom), 12'($urandom), DIV_A);
    repeat (4) @(negedge clk);
    model(streamA, eV, eE, eO);
    vectors++;
    if (vCntA !== eV || eCntA !== eE || {battA, currA, torqA} !== eO) begin
      $display("FAIL reset_mid_full: vld=%0d err=%0d out=%h, expected vld=%0d err=%0d out=%h",
               vCntA, eCntA, {battA, currA, torqA}, eV, eE, eO);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int eV, eE; logic [35:0] eO;
    logic [7:0] f [8];
    int fault, pos;
    repeat (4) begin
      repeat ($urandom_range(0, 2)) sendByte(1'b0, 8'($urandom), 1'b1, DIV_A);
      mkFrame(12'($urandom), 12'($urandom), 12'($urandom), f);
      fault = $urandom_range(0, 3);
      pos = $urandom_range(0, 7);
      if (fault == 2) f[2 * (pos % 3) + 2][7:4] = 4'($urandom_range(1, 15));
      for (int i = 0; i < 8; i++) sendByte(1'b0, f[i], !(fault == 1 && i == pos), DIV_A);
      repeat (4) @(negedge clk);
      model(streamA, eV, eE, eO);
      vectors++;
      if (vCntA !== eV || eCntA !== eE || {battA, currA, torqA} !== eO) begin
        $display("FAIL random_frame: vld=%0d err=%0d out=%h, expected vld=%0d err=%0d out=%h",
                 vCntA, eCntA, {battA, currA, torqA}, eV, eE, eO);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int eV, eE; logic [35:0] eO;
    sendFrame(1'b1, 12'($urandom), 12'($urandom), 12'($urandom), PER_B);
    sendFrame(1'b1, 12'($urandom), 12'($urandom), 12'($urandom), PER_B);
    repeat (4) @(negedge clk);
    model(streamB, eV, eE, eO);
    vectors++;
    if (vCntB !== 2 || eV !== 2 || eCntB !== 0) begin
      $display("FAIL back_to_back_counts: vld=%0d err=%0d, expected vld=2 err=0", vCntB, eCntB);
      miscompares++;
    end
    vectors++;
    if ({battB, currB, torqB} !== eO) begin
      $display("FAIL back_to_back_outputs: got %h, expected %h", {battB, currB, torqB}, eO);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    fork
      test_back_to_back();
      begin
        test_good_frame();
        test_resync();
        test_bad_stop();
        test_nibble();
        test_glitch();
        test_reset_mid();
        test_random();
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
